game_score: RTL and testbench
=============================

# game_score

Score-keeping stage for the T-rex game: runs a three-state game FSM (IDLE/RUN/OVER), converts elapsed run time into a 9-bit binary score with a programmable prescaler, and holds the session high score. Its `score` and `high_score` outputs feed the 9-bit binary-to-BCD converters, which drive the seven-segment display path. The collision detector and the start button conditioner sit upstream.

## Interface
- `TICKS_PER_POINT`, default 5_000_000: `clk` cycles per score point (10 points/s at 50 MHz). Legal range 2..2^24.
- `MAX_SCORE`, default 511: saturation value. Must be ≤ 511.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `start`  in  1  single-cycle start/restart pulse, already debounced.
- `collision`  in  1  level; high while the dino overlaps an obstacle.
- `pause`  in  1  level; freezes scoring while in RUN.
- `score`  out  9  current score, binary.
- `high_score`  out  9  best score this session, binary.
- `running`  out  1  high in RUN.
- `game_over`  out  1  high in OVER.
- `score_tick`  out  1  one-cycle pulse on every score increment.
- `new_record`  out  1  one-cycle pulse when `high_score` is updated.

## Operation
- State encoding is internal. State transitions:
  - IDLE → RUN on `start`.
  - RUN → OVER on `collision`.
  - OVER → RUN on `start`.
  - No other transitions. `pause` does not change state.
- Entering RUN:
  - clears the prescaler to 0;
  - clears `score` to 0 in the same edge.
- Prescaler behaviour in RUN with `pause`=0:
  - counts 0..TICKS_PER_POINT-1, then wraps to 0;
  - on the wrap edge, if `score` < MAX_SCORE, `score` increments by 1 and `score_tick` pulses.
- At MAX_SCORE:
  - `score` holds and `score_tick` stays 0;
  - the prescaler keeps wrapping;
  - the state remains RUN.
- `pause`=1 in RUN: the prescaler and `score` hold their values; no ticks are issued.
- In IDLE and OVER: the prescaler holds and `score` holds. In OVER, `score` keeps the final score for display.
- High-score update: on the RUN → OVER edge, if `score` > `high_score`, then `high_score` takes `score` and `new_record` pulses for one cycle. The comparison is strict: a tie does not update.
- Priority rules:
  - In RUN, `collision` beats a same-cycle prescaler wrap. The state goes to OVER, `score` is not incremented, and no tick is issued.
  - In RUN, `collision` beats `start`.
  - In IDLE and OVER, `collision` is ignored.
  - In RUN, `start` is ignored.
- `collision` held high while in OVER with a `start` pulse: the state goes to RUN. On the next cycle, if `collision` is still high, the state returns to OVER and the `high_score` compare runs against `score`=0.

## Timing
- Reset values when `rst_n`=0 at a rising edge:
  - state IDLE, prescaler 0;
  - `score`=0, `high_score`=0;
  - `running`=0, `game_over`=0;
  - `score_tick`=0, `new_record`=0.
- Reset in the middle of RUN or OVER clears everything, including `high_score`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `running` and `game_over` are valid in the cycle after the transition edge.
- First increment: `score` reaches 1 at TICKS_PER_POINT edges after the edge that accepted `start`.
- `score_tick` is high in the same cycle that the new `score` is visible.
- `new_record` is high in the same cycle that the new `high_score` is visible, which is the first cycle with `game_over`=1.

## Configuration
- Macro `GAME_SCORE_HIGH_SCORE_EN`.
- When defined: the high-score register, compare logic and `new_record` are built as described above.
- When undefined:
  - no high-score register or comparator is built;
  - `high_score` is tied to 0;
  - `new_record` is tied to 0;
  - the FSM and score behaviour are unchanged.

## Test plan
All scenarios use TICKS_PER_POINT=4 and MAX_SCORE=511 unless stated otherwise.
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → all outputs 0, state IDLE. Asserting `collision` in IDLE causes no change.
- **Counting:** `start` pulse, then 12 cycles in RUN → `score` steps 1, 2, 3 at edges 4, 8, 12; `score_tick` is high exactly 3 cycles.
- **Pause, then collision:** pause for 10 cycles in the middle of a prescaler count → the count resumes from its frozen value. A `collision` coinciding with a wrap edge → `score` unchanged, `game_over`=1, no tick.
- **High score:**
  - game 1 ends at 5 → `high_score`=5 with a `new_record` pulse;
  - game 2 ends at 5 → no update;
  - game 3 ends at 7 → `high_score`=7 with a pulse.
- **Saturation:** MAX_SCORE=3, run for 40 cycles → `score` stays at 3 and `score_tick` count is 3. A later collision → OVER with `score`=3.
- **Reset mid-game, and macro off:** drop `rst_n` at `score`=6 in RUN → all outputs 0 on the next cycle. With the macro undefined, repeating the high-score test → `high_score` and `new_record` stay 0.

Source files
------------

// File: rtl/game_score.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_score                                                    |
// | Purpose  : T-rex game FSM, prescaled run-time score, session high score. |
// |            High-score logic built only when GAME_SCORE_HIGH_SCORE_EN set.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module game_score #(
    parameter int TICKS_PER_POINT = 5_000_000,
    parameter int MAX_SCORE       = 511
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       collision,
    input  logic       pause,
    output logic [8:0] score,
    output logic [8:0] high_score,
    output logic       running,
    output logic       game_over,
    output logic       score_tick,
    output logic       new_record
);

    localparam int         c_PW   = $clog2(TICKS_PER_POINT);
    localparam logic [c_PW-1:0] c_WRAP = c_PW'(TICKS_PER_POINT - 1);
    localparam logic [8:0] c_MAX  = 9'(MAX_SCORE);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_OVER = 2'd2;

    logic [1:0]      r_state;
    logic [c_PW-1:0] r_presc;
    logic [8:0]      r_score;
    logic            r_running;
    logic            r_game_over;
    logic            r_score_tick;

    logic [1:0]      w_nxt_state;
    logic            w_enter_run;
    logic            w_advance;
    logic            w_wrap;
    logic            w_game_end;

    // Collision outranks start in RUN; both inputs are ignored where no edge exists.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            c_IDLE:  if (start)     w_nxt_state = c_RUN;
            c_RUN:   if (collision) w_nxt_state = c_OVER;
            c_OVER:  if (start)     w_nxt_state = c_RUN;
            default: w_nxt_state = c_IDLE;
        endcase
    end

    assign w_enter_run = (r_state != c_RUN) && (w_nxt_state == c_RUN);
    assign w_game_end  = (r_state == c_RUN) && collision;
    assign w_advance   = (r_state == c_RUN) && !collision && !pause;
    assign w_wrap      = (r_presc == c_WRAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_presc      <= '0;
            r_score      <= '0;
            r_running    <= 1'b0;
            r_game_over  <= 1'b0;
            r_score_tick <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_running    <= (w_nxt_state == c_RUN);
            r_game_over  <= (w_nxt_state == c_OVER);
            r_score_tick <= 1'b0;
            if (w_enter_run) begin
                r_presc <= '0;
                r_score <= '0;
            end else if (w_advance) begin
                if (w_wrap) begin
                    r_presc <= '0;
                    if (r_score < c_MAX) begin
                        r_score      <= r_score + 9'd1;
                        r_score_tick <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign score      = r_score;
    assign running    = r_running;
    assign game_over  = r_game_over;
    assign score_tick = r_score_tick;

`ifdef GAME_SCORE_HIGH_SCORE_EN
    logic [8:0] r_high_score;
    logic       r_new_record;

    // Strict compare: a tie keeps the old record and raises no pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_high_score <= '0;
            r_new_record <= 1'b0;
        end else begin
            r_new_record <= 1'b0;
            if (w_game_end && (r_score > r_high_score)) begin
                r_high_score <= r_score;
                r_new_record <= 1'b1;
            end
        end
    end

    assign high_score = r_high_score;
    assign new_record = r_new_record;
`else
    assign high_score = '0;
    assign new_record = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_score.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_game_score                                                 |
// | Purpose  : Self-checking bench for game_score (vector table, directed    |
// |            corner sequences, randomized run against a reference model).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_game_score;

`ifdef GAME_SCORE_HIGH_SCORE_EN
    localparam bit c_HS_EN = 1'b1;
`else
    localparam bit c_HS_EN = 1'b0;
`endif
    localparam int c_TPP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0, start = 1'b0, collision = 1'b0, pause = 1'b0;
    logic [8:0] score0, high0, score1, high1;
    logic       run0, over0, tick0, nr0, run1, over1, tick1, nr1;

    always #5 clk = ~clk;

    game_score #(.TICKS_PER_POINT(c_TPP), .MAX_SCORE(511)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .collision(collision), .pause(pause),
        .score(score0), .high_score(high0), .running(run0), .game_over(over0),
        .score_tick(tick0), .new_record(nr0));

    game_score #(.TICKS_PER_POINT(c_TPP), .MAX_SCORE(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .collision(collision), .pause(pause),
        .score(score1), .high_score(high1), .running(run1), .game_over(over1),
        .score_tick(tick1), .new_record(nr1));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game phase as a small integer, times and scores as plain ints.
    int m_phase[2];  // 0 idle, 1 playing, 2 finished
    int m_ticks[2];
    int m_score[2];
    int m_best[2];
    bit m_tick[2];
    bit m_rec[2];
    int m_limit[2] = '{511, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            m_tick[m] = 1'b0;
            m_rec[m]  = 1'b0;
            if (!rst_n) begin
                m_phase[m] = 0; m_ticks[m] = 0; m_score[m] = 0; m_best[m] = 0;
            end else if (m_phase[m] == 1) begin
                if (collision) begin
                    m_phase[m] = 2;
                    if (c_HS_EN && m_score[m] > m_best[m]) begin
                        m_best[m] = m_score[m];
                        m_rec[m]  = 1'b1;
                    end
                end else if (!pause) begin
                    m_ticks[m] = (m_ticks[m] + 1) % c_TPP;
                    if (m_ticks[m] == 0 && m_score[m] < m_limit[m]) begin
                        m_score[m]++;
                        m_tick[m] = 1'b1;
                    end
                end
            end else if (start) begin
                m_phase[m] = 1; m_ticks[m] = 0; m_score[m] = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_word(input int m);
        return {10'd0, 9'(m_score[m]), 9'(m_best[m]), m_phase[m] == 1, m_phase[m] == 2,
                m_tick[m], m_rec[m]};
    endfunction

    // One clock: drive inputs, advance model on the edge, compare #1 later.
    task automatic cyc(input logic r, input logic s, input logic c, input logic p);
        rst_n = r; start = s; collision = c; pause = p;
        @(posedge clk);
        model_edge();
        #1;
        check("model_dut", {10'd0, score0, high0, run0, over0, tick0, nr0}, model_word(0));
        check("model_sat", {10'd0, score1, high1, run1, over1, tick1, nr1}, model_word(1));
    endtask

    typedef struct {
        logic       r, s, c, p;
        logic [8:0] sc;
        logic       run, ovr, tk;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic r, s, c, p, input int sc, input logic run, ovr, tk);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.p = p; v.sc = 9'(sc); v.run = run; v.ovr = ovr; v.tk = tk;
        return v;
    endfunction

    // Plays one game to exactly n points and ends it on the following edge.
    task automatic play(input int n, input int exp_best, input logic exp_rec);
        cyc(1, 1, 0, 0);
        repeat (c_TPP * n) cyc(1, 0, 0, 0);
        check("play_score", 32'(score0), 32'(n));
        cyc(1, 0, 1, 0);
        check("play_over", {score0, over0, run0}, {9'(n), 1'b1, 1'b0});
        check("play_best", {high0, nr0}, {(c_HS_EN ? 9'(exp_best) : 9'd0), c_HS_EN & exp_rec});
    endtask

    int ticks;

    initial begin
        for (int i = 0; i < 3; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(1, 0, 1, 0, 0, 0, 0, 0);
        tbl[4] = mk(1, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 5; i < 17; i++)
            tbl[i] = mk(1, 0, 0, 0, (i - 4) / c_TPP, 1, 0, ((i - 4) % c_TPP) == 0);

        // Reset, idle collision and the first three points
        ticks = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].p);
            check($sformatf("tbl_%0d", i), {run0, over0, tick0, score0},
                  {tbl[i].run, tbl[i].ovr, tbl[i].tk, tbl[i].sc});
            if (i >= 5) ticks += int'(tick0);
        end
        check("count_ticks", 32'(ticks), 32'd3);

        // Pause mid-count: prescaler frozen at 2, resumes and wraps two edges later
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        repeat (10) cyc(1, 0, 0, 1);
        check("pause_hold", {score0, tick0}, {9'd3, 1'b0});
        cyc(1, 0, 0, 0);
        check("resume_1", {score0, tick0}, {9'd3, 1'b0});
        cyc(1, 0, 0, 0);
        check("resume_2", {score0, tick0}, {9'd4, 1'b1});

        // Collision on a wrap edge wins over the increment
        repeat (c_TPP - 1) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        check("coll_wrap", {score0, over0, tick0}, {9'd4, 1'b1, 1'b0});
        check("first_rec", {high0, nr0}, {(c_HS_EN ? 9'd4 : 9'd0), c_HS_EN});

        // Three games: record, tie, record
        play(5, 5, 1'b1);
        play(5, 5, 1'b0);
        play(7, 7, 1'b1);

        // Collision held through a restart: one RUN cycle, then back to OVER at 0
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        check("held_restart", {run0, over0, score0}, {1'b1, 1'b0, 9'd0});
        cyc(1, 0, 1, 0);
        check("held_reover", {over0, score0, nr0}, {1'b1, 9'd0, 1'b0});

        // Saturation on the MAX_SCORE=3 instance
        cyc(1, 1, 0, 0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 0, 0);
            ticks += int'(tick1);
        end
        check("sat_score", {score1, run1}, {9'd3, 1'b1});
        check("sat_ticks", 32'(ticks), 32'd3);
        cyc(1, 0, 1, 0);
        check("sat_over", {score1, over1}, {9'd3, 1'b1});

        // Reset in the middle of a game
        cyc(1, 1, 0, 0);
        repeat (6 * c_TPP) cyc(1, 0, 0, 0);
        check("pre_rst", 32'(score0), 32'd6);
        cyc(0, 0, 0, 0);
        check("mid_rst", {score0, high0, run0, over0, tick0, nr0, score1, high1, run1, over1},
              32'd0);

        // Randomized play against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
